// File: rtl/bus_ecc_pkg.sv
// Shared SECDED helpers for the bus codec.
// Codeword layout: {data, overall, check[P_W-1:0]}. Data bits occupy Hamming
// positions 1..DATA_W+P_W in ascending order, skipping powers of two.
// Functions work on maximum-width vectors; callers zero-extend and truncate.
package bus_ecc_pkg;

  localparam int unsigned MAX_DW = 64;
  localparam int unsigned MAX_PW = 7;
  localparam int unsigned MAX_CW = MAX_DW + MAX_PW + 1;

  typedef enum logic [1:0] {
    CLEAN = 2'd0,
    CE    = 2'd1,
    UE    = 2'd2
  } ecc_status_e;

  typedef struct packed {
    logic       hit;
    logic [5:0] idx;
  } data_idx_t;

  // Smallest p with 2**p >= dw + p + 1.
  function automatic int unsigned calc_pw(input int unsigned dw);
    int unsigned p;
    p = 1;
    while ((32'd1 << p) < (dw + p + 32'd1)) p++;
    return p;
  endfunction

  // Hamming position of data bit idx.
  function automatic logic [MAX_PW-1:0] data_pos(input int unsigned idx);
    int unsigned       cnt;
    logic [MAX_PW-1:0] pos;
    cnt = 0;
    pos = '0;
    for (int unsigned p = 3; p < MAX_CW; p++) begin
      if ((p & (p - 32'd1)) != 0) begin
        if (cnt == idx) pos = MAX_PW'(p);
        cnt++;
      end
    end
    return pos;
  endfunction

  // Check bits are the XOR of the positions of all set data bits.
  function automatic logic [MAX_CW-1:0] secded_encode(input logic [MAX_DW-1:0] data,
                                                      input int unsigned dw,
                                                      input int unsigned pw);
    logic [MAX_PW-1:0] chk;
    logic              ovr;
    chk = '0;
    for (int unsigned i = 0; i < MAX_DW; i++) begin
      if (i < dw && data[6'(i)]) chk ^= data_pos(i);
    end
    ovr = (^data) ^ (^chk);
    return (MAX_CW'(data) << (pw + 1)) | (MAX_CW'(ovr) << pw) | MAX_CW'(chk);
  endfunction

  // Recomputed check XOR received check.
  function automatic logic [MAX_PW-1:0] secded_syndrome(input logic [MAX_CW-1:0] cw,
                                                        input int unsigned dw,
                                                        input int unsigned pw);
    logic [MAX_DW-1:0] d;
    logic [MAX_PW-1:0] mask;
    d    = MAX_DW'(cw >> (pw + 1));
    mask = MAX_PW'((32'd1 << pw) - 32'd1);
    return (MAX_PW'(secded_encode(d, dw, pw)) ^ MAX_PW'(cw)) & mask;
  endfunction

  // Map a syndrome to the data bit it names, if any.
  function automatic data_idx_t syn_to_data_idx(input logic [MAX_PW-1:0] syn,
                                                input int unsigned dw);
    data_idx_t r;
    r = '0;
    for (int unsigned i = 0; i < MAX_DW; i++) begin
      if (i < dw && data_pos(i) == syn) begin
        r.hit = 1'b1;
        r.idx = 6'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bus_ecc_pipe_reg.sv
// One valid/ready register slice.
// Ports: in_valid/in_ready_c/in_data upstream, out_valid/out_ready/out_data downstream.
// in_ready_c is combinational: the slice accepts when empty or draining.
module bus_ecc_pipe_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready_c,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  assign in_ready_c = !out_valid || out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready_c) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/bus_secded_codec.sv
// SECDED codec for the high-speed bus.
// TX: tx_valid/tx_ready/tx_data -> 1-cycle encode -> tx_cw_valid/tx_cw_ready/tx_cw,
//     with one-shot error injection (inj_arm, inj_mask).
// RX: rx_cw_valid/rx_cw_ready/rx_cw -> syndrome stage -> correct stage ->
//     rx_valid/rx_ready/rx_data with rx_ce/rx_ue qualifiers.
// Status: cnt_clr, saturating ce_count/ue_count, ue_sticky.
module bus_secded_codec
  import bus_ecc_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16,
  localparam int unsigned P_W   = calc_pw(DATA_W),
  localparam int unsigned CW_W  = DATA_W + P_W + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_cw_valid,
  input  logic              tx_cw_ready,
  output logic [CW_W-1:0]   tx_cw,
  input  logic              inj_arm,
  input  logic [CW_W-1:0]   inj_mask,
  input  logic              rx_cw_valid,
  output logic              rx_cw_ready,
  input  logic [CW_W-1:0]   rx_cw,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_ce,
  output logic              rx_ue,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  ce_count,
  output logic [CNT_W-1:0]  ue_count,
  output logic              ue_sticky
);

  // ---------------- TX path ----------------
  logic              inj_armed;
  logic [CW_W-1:0]   inj_mask_q;
  logic [CW_W-1:0]   tx_code_c;
  logic [CW_W-1:0]   tx_stage_in_c;
  logic              tx_accept_c;

  assign tx_code_c     = CW_W'(secded_encode(MAX_DW'(tx_data), DATA_W, P_W));
  assign tx_stage_in_c = tx_code_c ^ (inj_armed ? inj_mask_q : '0);
  assign tx_accept_c   = tx_valid && tx_ready;

  // Injection arm: a new arm in the consuming cycle keeps the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inj_armed  <= 1'b0;
      inj_mask_q <= '0;
    end else if (inj_arm) begin
      inj_armed  <= 1'b1;
      inj_mask_q <= inj_mask;
    end else if (tx_accept_c) begin
      inj_armed  <= 1'b0;
    end
  end

  bus_ecc_pipe_reg #(.W(CW_W)) u_tx_stage (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (tx_valid),
    .in_ready_c (tx_ready),
    .in_data    (tx_stage_in_c),
    .out_valid  (tx_cw_valid),
    .out_ready  (tx_cw_ready),
    .out_data   (tx_cw)
  );

  // ---------------- RX stage 1: syndrome ----------------
  logic [P_W-1:0]  syn_c;
  logic            par_c;
  logic [CW_W-1:0] s1_in_c;
  logic [CW_W-1:0] s1_q;
  logic            s1_valid;
  logic            s1_ready_c;

  assign syn_c   = P_W'(secded_syndrome(MAX_CW'(rx_cw), DATA_W, P_W));
  assign par_c   = ^rx_cw;
  assign s1_in_c = {rx_cw[CW_W-1:P_W+1], syn_c, par_c};

  bus_ecc_pipe_reg #(.W(CW_W)) u_rx_stage1 (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (rx_cw_valid),
    .in_ready_c (rx_cw_ready),
    .in_data    (s1_in_c),
    .out_valid  (s1_valid),
    .out_ready  (s1_ready_c),
    .out_data   (s1_q)
  );

  // ---------------- RX stage 2: correct ----------------
  logic [DATA_W-1:0] s1_raw;
  logic [P_W-1:0]    s1_syn;
  logic              s1_par;
  data_idx_t         idx_c;
  ecc_status_e       status_c;
  logic [DATA_W-1:0] corr_c;
  logic [DATA_W+1:0] s2_in_c;

  assign s1_raw = s1_q[CW_W-1:P_W+1];
  assign s1_syn = s1_q[P_W:1];
  assign s1_par = s1_q[0];

  // Odd parity with a zero or power-of-two syndrome is a lone overall/check flip.
  always_comb begin
    status_c = CLEAN;
    corr_c   = s1_raw;
    idx_c    = syn_to_data_idx(MAX_PW'(s1_syn), DATA_W);
    if (s1_par) begin
      if ((s1_syn & (s1_syn - P_W'(1))) == '0) begin
        status_c = CE;
      end else if (idx_c.hit) begin
        status_c = CE;
        corr_c   = s1_raw ^ (DATA_W'(1) << idx_c.idx);
      end else begin
        status_c = UE;
      end
    end else if (s1_syn != '0) begin
      status_c = UE;
    end
  end

  assign s2_in_c = {corr_c, status_c == CE, status_c == UE};

  bus_ecc_pipe_reg #(.W(DATA_W + 2)) u_rx_stage2 (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (s1_valid),
    .in_ready_c (s1_ready_c),
    .in_data    (s2_in_c),
    .out_valid  (rx_valid),
    .out_ready  (rx_ready),
    .out_data   ({rx_data, rx_ce, rx_ue})
  );

  // ---------------- Counters ----------------
  logic rx_fire_c;
  assign rx_fire_c = rx_valid && rx_ready;

  // Clear takes precedence; a same-cycle event is dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ce_count  <= '0;
      ue_count  <= '0;
      ue_sticky <= 1'b0;
    end else if (cnt_clr) begin
      ce_count  <= '0;
      ue_count  <= '0;
      ue_sticky <= 1'b0;
    end else if (rx_fire_c) begin
      if (rx_ce && ce_count != '1) ce_count <= ce_count + CNT_W'(1);
      if (rx_ue && ue_count != '1) ue_count <= ue_count + CNT_W'(1);
      if (rx_ue) ue_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bus_secded_codec.sv
// Scoreboard bench for bus_secded_codec (DATA_W=32, CNT_W=6).
// TX codewords loop back into RX through an XOR flip mask.
module tb_bus_secded_codec;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 39;
  localparam int unsigned CN = 6;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          tx_valid;
  logic          tx_ready;
  logic [DW-1:0] tx_data;
  logic          tx_cw_valid;
  logic          tx_cw_ready;
  logic [CW-1:0] tx_cw;
  logic          inj_arm;
  logic [CW-1:0] inj_mask;
  logic          rx_cw_valid;
  logic          rx_cw_ready;
  logic [CW-1:0] rx_cw;
  logic          rx_valid;
  logic          rx_ready;
  logic [DW-1:0] rx_data;
  logic          rx_ce;
  logic          rx_ue;
  logic          cnt_clr;
  logic [CN-1:0] ce_count;
  logic [CN-1:0] ue_count;
  logic          ue_sticky;

  logic [CW-1:0] flip;
  logic          sb_off;
  int            total = 0;
  int            bad = 0;
  int            stall_seen = 0;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          ce;
    logic          ue;
  } rx_exp_t;

  logic [CW-1:0] tx_q[$];
  rx_exp_t       rx_q[$];

  always #5 clk = ~clk;

  assign rx_cw       = tx_cw ^ flip;
  assign rx_cw_valid = tx_cw_valid;
  assign tx_cw_ready = rx_cw_ready;

  bus_secded_codec #(.DATA_W(DW), .CNT_W(CN)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_data     (tx_data),
    .tx_cw_valid (tx_cw_valid),
    .tx_cw_ready (tx_cw_ready),
    .tx_cw       (tx_cw),
    .inj_arm     (inj_arm),
    .inj_mask    (inj_mask),
    .rx_cw_valid (rx_cw_valid),
    .rx_cw_ready (rx_cw_ready),
    .rx_cw       (rx_cw),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_data     (rx_data),
    .rx_ce       (rx_ce),
    .rx_ue       (rx_ue),
    .cnt_clr     (cnt_clr),
    .ce_count    (ce_count),
    .ue_count    (ue_count),
    .ue_sticky   (ue_sticky)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference encoder: builds the Hamming word by position, then reorders.
  function automatic logic [CW-1:0] model_enc(input logic [DW-1:0] d);
    logic [63:0] h;
    logic [5:0]  chk;
    int          k;
    h = '0;
    k = 0;
    for (int p = 1; p <= 38; p++) begin
      if ((p & (p - 1)) != 0) begin
        h[6'(p)] = d[5'(k)];
        k++;
      end
    end
    for (int i = 0; i < 6; i++) begin
      logic c;
      c = 1'b0;
      for (int p = 1; p <= 38; p++) begin
        if (((p >> i) & 1) != 0) c ^= h[6'(p)];
      end
      chk[3'(i)] = c;
    end
    return {d, (^d) ^ (^chk), chk};
  endfunction

  // Monitor: handshakes are evaluated half a cycle ahead of the transfer edge.
  always @(negedge clk) begin
    if (reset_n && !sb_off) begin
      if (tx_cw_valid && tx_cw_ready) begin
        if (tx_q.size() == 0) check("tx_unexpected_word", 64'(1), 64'(0));
        else check("tx_cw", 64'(tx_cw), 64'(tx_q.pop_front()));
      end
      if (rx_valid && rx_ready) begin
        if (rx_q.size() == 0) check("rx_unexpected_word", 64'(1), 64'(0));
        else begin
          rx_exp_t e;
          e = rx_q.pop_front();
          check("rx_data", 64'(rx_data), 64'(e.d));
          check("rx_ce", 64'(rx_ce), 64'(e.ce));
          check("rx_ue", 64'(rx_ue), 64'(e.ue));
        end
      end
      if (!rx_cw_ready) begin
        stall_seen++;
        check("rx_cw_ready_low_only_on_stall", 64'(rx_valid && !rx_ready), 64'(1));
      end
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic [CW-1:0] txe,
                      input logic [DW-1:0] rxd, input logic ce, input logic ue);
    int n;
    rx_exp_t e;
    e.d = rxd; e.ce = ce; e.ue = ue;
    tx_q.push_back(txe);
    rx_q.push_back(e);
    tx_data  = d;
    tx_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!tx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("tx_ready_timeout", 64'(n), 64'(0));
    @(posedge clk); #2;
    tx_valid = 1'b0;
  endtask

  task automatic send_clean(input logic [DW-1:0] d);
    send(d, model_enc(d), d, 1'b0, 1'b0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((tx_q.size() != 0 || rx_q.size() != 0) && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    check("drain", 64'(tx_q.size() + rx_q.size()), 64'(0));
  endtask

  task automatic pulse_clr();
    cnt_clr = 1'b1;
    @(posedge clk); #2;
    cnt_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] w;
    int            n_spur;
    reset_n  = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    inj_arm  = 1'b0;
    inj_mask = '0;
    rx_ready = 1'b1;
    cnt_clr  = 1'b0;
    flip     = '0;
    sb_off   = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_tx_cw_valid", 64'(tx_cw_valid), 64'(0));
    check("rst_rx_valid", 64'(rx_valid), 64'(0));
    check("rst_tx_cw", 64'(tx_cw), 64'(0));
    check("rst_rx_data_flags", 64'({rx_data, rx_ce, rx_ue}), 64'(0));
    check("rst_counts", 64'({ce_count, ue_count, ue_sticky}), 64'(0));
    reset_n = 1'b1;
    @(posedge clk); #2;

    // Zero word and latency.
    send(32'h0, 39'h0, 32'h0, 1'b0, 1'b0);
    check("tx_latency_1", 64'(tx_cw_valid), 64'(1));
    @(posedge clk); #2;
    check("rx_not_yet_valid", 64'(rx_valid), 64'(0));
    @(posedge clk); #2;
    check("rx_latency_2", 64'(rx_valid), 64'(1));
    drain();
    // Hand-encoded vectors: data bit 0 at position 3, data bit 31 at position 38.
    send(32'h1, 39'h00_0000_00C3, 32'h1, 1'b0, 1'b0);
    send(32'h8000_0000, 39'h40_0000_0026, 32'h8000_0000, 1'b0, 1'b0);
    drain();

    // Single-bit corrections.
    flip = 39'd1 << 7;
    send(32'hDEAD_BEEF, model_enc(32'hDEAD_BEEF), 32'hDEAD_BEEF, 1'b1, 1'b0);
    drain();
    check("ce_count_one", 64'(ce_count), 64'(1));
    pulse_clr();
    for (int b = 0; b < 39; b++) begin
      flip = 39'd1 << b;
      send(32'hDEAD_BEEF, model_enc(32'hDEAD_BEEF), 32'hDEAD_BEEF, 1'b1, 1'b0);
      drain();
    end
    check("ce_count_39", 64'(ce_count), 64'(39));
    check("ue_count_zero", 64'(ue_count), 64'(0));

    // Double error, then a triple error whose syndrome (39) lies beyond the code.
    flip = (39'd1 << 7) | (39'd1 << 20);
    send(32'hDEAD_BEEF, model_enc(32'hDEAD_BEEF), 32'hDEAD_BEEF ^ 32'h0000_2001, 1'b0, 1'b1);
    drain();
    check("ue_count_one", 64'(ue_count), 64'(1));
    check("ue_sticky_set", 64'(ue_sticky), 64'(1));
    flip = (39'd1 << 33) | (39'd1 << 8) | (39'd1 << 7);
    send(32'hDEAD_BEEF, model_enc(32'hDEAD_BEEF), 32'hDEAD_BEEF ^ 32'h0400_0003, 1'b0, 1'b1);
    drain();
    check("ue_count_two", 64'(ue_count), 64'(2));
    check("ce_unchanged_by_ue", 64'(ce_count), 64'(39));
    pulse_clr();
    check("clr_counts", 64'({ce_count, ue_count, ue_sticky}), 64'(0));
    flip = '0;

    // One-shot injection on data bit 31.
    inj_mask = 39'd1 << 38;
    inj_arm  = 1'b1;
    @(posedge clk); #2;
    inj_arm = 1'b0;
    send(32'h1111_2222, model_enc(32'h1111_2222) ^ (39'd1 << 38), 32'h1111_2222, 1'b1, 1'b0);
    send_clean(32'h3333_4444);
    send_clean(32'h5555_6666);
    drain();
    check("inj_one_ce", 64'(ce_count), 64'(1));

    // Re-arm in the consuming cycle: two consecutive words corrupted.
    inj_mask = 39'd1 << 5;
    inj_arm  = 1'b1;
    @(posedge clk); #2;
    send(32'hAAAA_0001, model_enc(32'hAAAA_0001) ^ (39'd1 << 5), 32'hAAAA_0001, 1'b1, 1'b0);
    inj_arm = 1'b0;
    send(32'hAAAA_0002, model_enc(32'hAAAA_0002) ^ (39'd1 << 5), 32'hAAAA_0002, 1'b1, 1'b0);
    send_clean(32'hAAAA_0003);
    drain();
    check("rearm_ce_count", 64'(ce_count), 64'(3));

    // Backpressure on the consumer.
    stall_seen = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) send_clean(32'hA5A5_0000 + 32'(i));
      end
      begin
        repeat (3) @(posedge clk);
        #2;
        rx_ready = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rx_ready = 1'b1;
      end
    join
    drain();
    check("stall_observed", 64'(stall_seen > 0), 64'(1));

    // Saturation: 70 corrected words streamed back to back.
    flip = 39'd1 << 12;
    for (int i = 0; i < 70; i++) begin
      w = 32'h0F0F_0000 ^ 32'(i * 7);
      send(w, model_enc(w), w, 1'b1, 1'b0);
    end
    drain();
    check("ce_saturated", 64'(ce_count), 64'(63));
    flip = (39'd1 << 9) | (39'd1 << 30);
    send(32'h0, 39'h0, 32'h0 ^ 32'h0080_0004, 1'b0, 1'b1);
    drain();
    flip = '0;
    check("pre_reset_sticky", 64'(ue_sticky), 64'(1));

    // Reset in the middle of a stream, with injection armed.
    sb_off   = 1'b1;
    tx_data  = 32'h0000_1234;
    tx_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #2;
    end
    inj_mask = 39'd1 << 38;
    inj_arm  = 1'b1;
    @(posedge clk); #2;
    inj_arm = 1'b0;
    reset_n = 1'b0;
    #1;
    check("midrst_valids", 64'({tx_cw_valid, rx_valid}), 64'(0));
    check("midrst_counts", 64'({ce_count, ue_count, ue_sticky}), 64'(0));
    check("midrst_tx_cw", 64'(tx_cw), 64'(0));
    tx_valid = 1'b0;
    @(posedge clk); #2;
    reset_n = 1'b1;
    n_spur = 0;
    repeat (10) begin
      @(negedge clk);
      if (rx_valid || tx_cw_valid) n_spur++;
    end
    check("no_spurious_valid", 64'(n_spur), 64'(0));
    @(posedge clk); #2;
    sb_off = 1'b0;
    send_clean(32'h0BAD_F00D);
    drain();
    check("post_reset_no_inj", 64'({ce_count, ue_count}), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
